// File: rtl/decode_pipe.sv
// decode_pipe: F/D register, decode, Tnew/Tuse stall, E/M forwarding, branch resolve.
// Optional counters are built when DECODE_STATS_EN is defined.
module decode_pipe #(
  parameter int              XLEN       = 32,
  parameter int              PC_W       = 32,
  parameter logic [PC_W-1:0] RESET_PC   = PC_W'(32'h0000_3000),
  parameter int              DELAY_SLOT = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     F_ins,
  input  logic [PC_W-1:0] F_PC,
  input  logic            ext_stall,
  input  logic            ext_flush,
  output logic [4:0]      reg_adr1,
  output logic [4:0]      reg_adr2,
  input  logic [XLEN-1:0] reg_read1,
  input  logic [XLEN-1:0] reg_read2,
  input  logic [4:0]      E_dst,
  input  logic [4:0]      M_dst,
  input  logic [1:0]      E_tnew,
  input  logic [1:0]      M_tnew,
  input  logic [XLEN-1:0] E_data,
  input  logic [XLEN-1:0] M_data,
  output logic            stall,
  output logic            br_taken,
  output logic [PC_W-1:0] DnPC,
  output logic [31:0]     D_ins,
  output logic [PC_W-1:0] D_PC,
  output logic            D_valid,
  output logic [XLEN-1:0] imm32,
  output logic [XLEN-1:0] reg_rs,
  output logic [XLEN-1:0] reg_rt,
  output logic [PC_W-1:0] link_addr,
  output logic [31:0]     stat_stalls,
  output logic [31:0]     stat_taken
);

  typedef enum logic [3:0] {
    OP_NOP, OP_ADDU, OP_SUBU, OP_ORI,
    OP_LUI, OP_LW, OP_SW, OP_BEQ,
    OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ,
    OP_BGEZ, OP_J, OP_JAL, OP_JR
  } op_e;

  logic [31:0]     ins_q, ins_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  logic [5:0]  opc, fn;
  logic [4:0]  rs, rt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  op_e         op;

  assign opc   = ins_q[31:26];
  assign rs    = ins_q[25:21];
  assign rt    = ins_q[20:16];
  assign fn    = ins_q[5:0];
  assign imm16 = ins_q[15:0];
  assign imm26 = ins_q[25:0];

  always_comb begin
    op = OP_NOP;
    case (opc)
      6'h00: begin
        case (fn)
          6'h21:   op = OP_ADDU;
          6'h23:   op = OP_SUBU;
          6'h08:   op = OP_JR;
          default: op = OP_NOP;
        endcase
      end
      6'h01: begin
        case (rt)
          5'd0:    op = OP_BLTZ;
          5'd1:    op = OP_BGEZ;
          default: op = OP_NOP;
        endcase
      end
      6'h02:   op = OP_J;
      6'h03:   op = OP_JAL;
      6'h04:   op = OP_BEQ;
      6'h05:   op = OP_BNE;
      6'h06:   op = OP_BLEZ;
      6'h07:   op = OP_BGTZ;
      6'h0D:   op = OP_ORI;
      6'h0F:   op = OP_LUI;
      6'h23:   op = OP_LW;
      6'h2B:   op = OP_SW;
      default: op = OP_NOP;
    endcase
  end

  logic       rs_use, rt_use;
  logic [1:0] rs_tuse, rt_tuse;

  always_comb begin
    rs_use  = 1'b0;
    rt_use  = 1'b0;
    rs_tuse = 2'd0;
    rt_tuse = 2'd0;
    case (op)
      OP_ADDU, OP_SUBU: begin
        rs_use  = 1'b1;
        rt_use  = 1'b1;
        rs_tuse = 2'd1;
        rt_tuse = 2'd1;
      end
      OP_ORI, OP_LW: begin
        rs_use  = 1'b1;
        rs_tuse = 2'd1;
      end
      OP_SW: begin
        rs_use  = 1'b1;
        rt_use  = 1'b1;
        rs_tuse = 2'd1;
        rt_tuse = 2'd2;
      end
      OP_BEQ, OP_BNE: begin
        rs_use = 1'b1;
        rt_use = 1'b1;
      end
      OP_BLEZ, OP_BGTZ, OP_BLTZ, OP_BGEZ, OP_JR:
        rs_use = 1'b1;
      default: ;
    endcase
  end

  logic haz_rs, haz_rt;

  assign haz_rs = rs_use && rs != 5'd0 &&
                  ((rs == E_dst && E_tnew > rs_tuse) ||
                   (rs == M_dst && M_tnew > rs_tuse));
  assign haz_rt = rt_use && rt != 5'd0 &&
                  ((rt == E_dst && E_tnew > rt_tuse) ||
                   (rt == M_dst && M_tnew > rt_tuse));
  assign stall  = ext_stall | haz_rs | haz_rt;

  // E is younger than M, so its result wins when both match.
  assign reg_rs = (rs == 5'd0) ? '0 :
                  (rs == E_dst && E_tnew == 2'd0) ? E_data :
                  (rs == M_dst && M_tnew == 2'd0) ? M_data :
                  reg_read1;
  assign reg_rt = (rt == 5'd0) ? '0 :
                  (rt == E_dst && E_tnew == 2'd0) ? E_data :
                  (rt == M_dst && M_tnew == 2'd0) ? M_data :
                  reg_read2;

  assign reg_adr1 = rs;
  assign reg_adr2 = rt;

  always_comb begin
    case (op)
      OP_ORI:  imm32 = {{(XLEN-16){1'b0}}, imm16};
      OP_LUI:  imm32 = XLEN'({imm16, 16'h0000});
      default: imm32 = {{(XLEN-16){imm16[15]}}, imm16};
    endcase
  end

  logic signed [XLEN-1:0] srs;
  logic                   take;
  logic [PC_W-1:0]        pc4, br_off, tgt;

  assign srs    = $signed(reg_rs);
  assign pc4    = pc_q + PC_W'(4);
  assign br_off = {{(PC_W-18){imm16[15]}}, imm16, 2'b00};

  always_comb begin
    take = 1'b0;
    tgt  = pc4 + br_off;
    case (op)
      OP_BEQ:  take = (reg_rs == reg_rt);
      OP_BNE:  take = (reg_rs != reg_rt);
      OP_BLEZ: take = (srs <= 0);
      OP_BGTZ: take = (srs > 0);
      OP_BLTZ: take = (srs < 0);
      OP_BGEZ: take = (srs >= 0);
      OP_J, OP_JAL: begin
        take = 1'b1;
        tgt  = {pc_q[PC_W-1:28], imm26, 2'b00};
      end
      OP_JR: begin
        take = 1'b1;
        tgt  = PC_W'(reg_rs);
      end
      default: take = 1'b0;
    endcase
  end

  assign br_taken  = valid_q & ~stall & take;
  assign DnPC      = br_taken ? tgt : pc4;
  assign link_addr = pc_q + PC_W'((DELAY_SLOT != 0) ? 8 : 4);

  always_comb begin
    ins_d   = ins_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    if (ext_flush || (!stall && DELAY_SLOT == 0 && br_taken)) begin
      ins_d   = '0;
      pc_d    = RESET_PC;
      valid_d = 1'b0;
    end else if (!stall) begin
      ins_d   = F_ins;
      pc_d    = F_PC;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins_q   <= '0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      ins_q   <= ins_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign D_ins   = ins_q;
  assign D_PC    = pc_q;
  assign D_valid = valid_q;

`ifdef DECODE_STATS_EN
  logic [31:0] stalls_q, stalls_d, taken_q, taken_d;

  assign stalls_d = stalls_q + 32'(stall);
  assign taken_d  = taken_q + 32'(br_taken);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stalls_q <= '0;
      taken_q  <= '0;
    end else begin
      stalls_q <= stalls_d;
      taken_q  <= taken_d;
    end
  end

  assign stat_stalls = stalls_q;
  assign stat_taken  = taken_q;
`else
  assign stat_stalls = '0;
  assign stat_taken  = '0;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed vectors for decode_pipe (delay-slot and squash builds).
// Counter expectations follow DECODE_STATS_EN.
module tb_decode_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] F_ins, F_PC;
  logic        ext_stall, ext_flush;
  logic [31:0] reg_read1, reg_read2;
  logic [4:0]  E_dst, M_dst;
  logic [1:0]  E_tnew, M_tnew;
  logic [31:0] E_data, M_data;

  logic [4:0]  reg_adr1, reg_adr2, reg_adr1_0, reg_adr2_0;
  logic        stall, br_taken, D_valid;
  logic        stall0, br_taken0, D_valid0;
  logic [31:0] DnPC, D_ins, D_PC, imm32, reg_rs, reg_rt, link_addr;
  logic [31:0] DnPC0, D_ins0, D_PC0, imm32_0, reg_rs0, reg_rt0, link_addr0;
  logic [31:0] stat_stalls, stat_taken, stat_stalls0, stat_taken0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_pipe dut (
    .clk(clk), .reset(reset), .F_ins(F_ins), .F_PC(F_PC),
    .ext_stall(ext_stall), .ext_flush(ext_flush),
    .reg_adr1(reg_adr1), .reg_adr2(reg_adr2),
    .reg_read1(reg_read1), .reg_read2(reg_read2),
    .E_dst(E_dst), .M_dst(M_dst), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_data(E_data), .M_data(M_data),
    .stall(stall), .br_taken(br_taken), .DnPC(DnPC),
    .D_ins(D_ins), .D_PC(D_PC), .D_valid(D_valid),
    .imm32(imm32), .reg_rs(reg_rs), .reg_rt(reg_rt),
    .link_addr(link_addr),
    .stat_stalls(stat_stalls), .stat_taken(stat_taken)
  );

  decode_pipe #(.DELAY_SLOT(0)) dut0 (
    .clk(clk), .reset(reset), .F_ins(F_ins), .F_PC(F_PC),
    .ext_stall(ext_stall), .ext_flush(ext_flush),
    .reg_adr1(reg_adr1_0), .reg_adr2(reg_adr2_0),
    .reg_read1(reg_read1), .reg_read2(reg_read2),
    .E_dst(E_dst), .M_dst(M_dst), .E_tnew(E_tnew), .M_tnew(M_tnew),
    .E_data(E_data), .M_data(M_data),
    .stall(stall0), .br_taken(br_taken0), .DnPC(DnPC0),
    .D_ins(D_ins0), .D_PC(D_PC0), .D_valid(D_valid0),
    .imm32(imm32_0), .reg_rs(reg_rs0), .reg_rt(reg_rt0),
    .link_addr(link_addr0),
    .stat_stalls(stat_stalls0), .stat_taken(stat_taken0)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clr();
    ext_stall = 1'b0;
    ext_flush = 1'b0;
    E_dst = '0; M_dst = '0;
    E_tnew = '0; M_tnew = '0;
    E_data = '0; M_data = '0;
    reg_read1 = '0; reg_read2 = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] ins, input logic [31:0] pc);
    clr();
    F_ins = ins;
    F_PC  = pc;
    step();
  endtask

  localparam logic [31:0] ADDU = 32'h0023_1021;  // addu $2,$1,$3
  localparam logic [31:0] ORI5 = 32'h34A6_0001;  // ori $6,$5,1
  localparam logic [31:0] BEQ  = 32'h1084_0003;  // beq $4,$4,+3

  initial begin
    reset = 1'b1;
    clr();
    F_ins = '0;
    F_PC  = 32'h3000;
    #2;
    chk("rst_valid", 32'(D_valid), 32'd0);
    chk("rst_ins", D_ins, 32'h0);
    chk("rst_pc", D_PC, 32'h3000);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_taken", 32'(br_taken), 32'd0);
    step();
    reset = 1'b0;

    load(ADDU, 32'h3000);
    chk("addu_valid", 32'(D_valid), 32'd1);
    chk("addu_adr1", 32'(reg_adr1), 32'd1);
    chk("addu_adr2", 32'(reg_adr2), 32'd3);
    E_dst = 5'd1; E_tnew = 2'd2; #1;
    chk("lwE_stall", 32'(stall), 32'd1);
    F_ins = ORI5;
    step();
    chk("stall_hold", D_ins, ADDU);
    E_dst = 5'd0; M_dst = 5'd1; M_tnew = 2'd2; #1;
    chk("M2_stall", 32'(stall), 32'd1);
    M_tnew = 2'd1; reg_read1 = 32'h11; M_data = 32'h55; #1;
    chk("M1_nostall", 32'(stall), 32'd0);
    chk("M1_nofwd", reg_rs, 32'h11);
    M_tnew = 2'd0; reg_read2 = 32'h33; #1;
    chk("M0_fwd", reg_rs, 32'h55);
    chk("rt_rf", reg_rt, 32'h33);

    load(ORI5, 32'h3004);
    E_dst = 5'd5; E_data = 32'd7; M_dst = 5'd5; M_data = 32'd9; #1;
    chk("fwd_E_prio", reg_rs, 32'd7);
    chk("ori_imm", imm32, 32'h1);
    E_dst = 5'd0; #1;
    chk("fwd_M", reg_rs, 32'd9);
    load(32'h3406_0001, 32'h3008);
    E_data = 32'd7; M_data = 32'd9; reg_read1 = 32'h99; #1;
    chk("fwd_zero", reg_rs, 32'h0);

    load(32'h3401_8001, 32'h300C);
    chk("ori_zext", imm32, 32'h0000_8001);
    load(32'h3C01_8001, 32'h300C);
    chk("lui_imm", imm32, 32'h8001_0000);
    load(32'h8C41_FFFC, 32'h300C);
    chk("lw_sext", imm32, 32'hFFFF_FFFC);

    load(32'hAC43_0000, 32'h300C);
    E_dst = 5'd3; E_tnew = 2'd2; #1;
    chk("sw_rt_t2", 32'(stall), 32'd0);
    E_tnew = 2'd3; #1;
    chk("sw_rt_t3", 32'(stall), 32'd1);
    E_dst = 5'd2; E_tnew = 2'd2; #1;
    chk("sw_rs_t2", 32'(stall), 32'd1);

    load(BEQ, 32'h3010);
    chk("beq_taken", 32'(br_taken), 32'd1);
    chk("beq_tgt", DnPC, 32'h3020);
    chk("beq_taken0", 32'(br_taken0), 32'd1);
    load(ORI5, 32'h3014);
    chk("ds_ins", D_ins, ORI5);
    chk("ds_pc", D_PC, 32'h3014);
    chk("sq_valid", 32'(D_valid0), 32'd0);
    chk("sq_ins", D_ins0, 32'h0);
    chk("sq_pc", D_PC0, 32'h3000);

    load(BEQ, 32'h3010);
    E_dst = 5'd4; E_tnew = 2'd1; #1;
    chk("beq_haz", 32'(stall), 32'd1);
    chk("beq_haz_nt", 32'(br_taken), 32'd0);
    chk("beq_haz_pc", DnPC, 32'h3014);

    load(32'h1485_0002, 32'h3020);
    reg_read1 = 32'd1; reg_read2 = 32'd1; #1;
    chk("bne_nt", 32'(br_taken), 32'd0);
    chk("bne_nt_pc", DnPC, 32'h3024);
    reg_read2 = 32'd2; #1;
    chk("bne_t_pc", DnPC, 32'h302C);

    load(32'h0480_0002, 32'h3030);
    reg_read1 = 32'hFFFF_FFFF; #1;
    chk("bltz_neg", 32'(br_taken), 32'd1);
    chk("bltz_tgt", DnPC, 32'h303C);
    reg_read1 = 32'h0; #1;
    chk("bltz_zero", 32'(br_taken), 32'd0);
    load(32'h0481_0002, 32'h3030);
    chk("bgez_zero", 32'(br_taken), 32'd1);

    load(32'h0, 32'h3040);
    load(32'h0C00_0100, 32'h3000);
    chk("jal_taken", 32'(br_taken), 32'd1);
    chk("jal_tgt", DnPC, 32'h0000_0400);
    chk("jal_link", link_addr, 32'h3008);
    chk("jal_link0", link_addr0, 32'h3004);
    chk("jal_tgt0", DnPC0, 32'h0000_0400);

    load(32'h03E0_0008, 32'h3050);
    reg_read1 = 32'h1234; #1;
    chk("jr_taken", 32'(br_taken), 32'd1);
    chk("jr_tgt", DnPC, 32'h1234);

    load(ADDU, 32'h3060);
    E_dst = 5'd1; E_tnew = 2'd2; #1;
    chk("fl_stall", 32'(stall), 32'd1);
    ext_flush = 1'b1;
    step();
    chk("fl_valid", 32'(D_valid), 32'd0);
    chk("fl_ins", D_ins, 32'h0);
    chk("fl_pc", D_PC, 32'h3000);

    load(ADDU, 32'h3070);
    E_dst = 5'd1; E_tnew = 2'd2; #1;
    chk("ar_stall", 32'(stall), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("ar_valid", 32'(D_valid), 32'd0);
    chk("ar_ins", D_ins, 32'h0);
    chk("ar_pc", D_PC, 32'h3000);
    chk("ar_stall0", 32'(stall), 32'd0);
    chk("ar_taken", 32'(br_taken), 32'd0);
    step();
    clr();
    reset = 1'b0;
    ext_stall = 1'b1;
    repeat (3) step();
    load(BEQ, 32'h3010);
    load(BEQ, 32'h3014);
    load(32'h0, 32'h3018);
`ifdef DECODE_STATS_EN
    chk("st_stalls", stat_stalls, 32'd3);
    chk("st_taken", stat_taken, 32'd2);
`else
    chk("st_stalls", stat_stalls, 32'd0);
    chk("st_taken", stat_taken, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule
